// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core pipeline.
// The fetch stage uses the state enum, the SQI setup lengths and the address-nibble helper.
package idli_pkg;

  typedef logic [1:0]  ctr_t;
  typedef logic [3:0]  slice_t;
  typedef logic [15:0] data_t;
  typedef logic [15:0] pc_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } fe_state_t;

  localparam logic [7:0] SQI_CMD_DEFAULT       = 8'hEB;
  localparam int         DUMMY_NIBBLES_DEFAULT = 4;
  localparam int         SQI_CMD_NIBBLES       = 2;
  localparam int         SQI_ADDR_NIBBLES      = 6;
  localparam int         SQI_SETUP_NIBBLES     = SQI_CMD_NIBBLES + SQI_ADDR_NIBBLES
                                                 + DUMMY_NIBBLES_DEFAULT;

  // Word PC becomes a 24-bit byte address; idx 0 selects the most significant nibble.
  function automatic slice_t addr_nibble(input pc_t pc, input logic [2:0] idx);
    logic [23:0] byte_addr;
    byte_addr = {7'b0, pc, 1'b0};
    return slice_t'(byte_addr >> (5'd20 - {idx, 2'b00}));
  endfunction

endpackage

// File: rtl/idli_fetch_sqi_seq_m.sv
// SQI read sequencer: IDLE -> CMD -> ADDR -> DUMMY -> DATA, restarting on redirect.
// Drives chip select, output enable and the outgoing command/address nibbles.
module idli_fetch_sqi_seq_m
  import idli_pkg::*;
#(
  parameter logic [7:0] SQI_CMD       = SQI_CMD_DEFAULT,
  parameter int         DUMMY_NIBBLES = DUMMY_NIBBLES_DEFAULT
) (
  input  logic      i_fe_gck,
  input  logic      i_fe_rst,
  input  ctr_t      i_seq_ctr,
  input  logic      i_seq_restart,
  input  pc_t       i_seq_pc,
  output fe_state_t o_seq_state,
  output logic      o_seq_cs_n,
  output logic      o_seq_oe,
  output slice_t    o_seq_out
);

  localparam int SETUP_N = SQI_CMD_NIBBLES + SQI_ADDR_NIBBLES + DUMMY_NIBBLES;
  localparam int NIB_W   = $clog2(SETUP_N + 1);

  localparam logic [NIB_W-1:0] CMD_LAST   = NIB_W'(SQI_CMD_NIBBLES - 1);
  localparam logic [NIB_W-1:0] ADDR_LAST  = NIB_W'(SQI_CMD_NIBBLES + SQI_ADDR_NIBBLES - 1);
  localparam logic [NIB_W-1:0] SETUP_LAST = NIB_W'(SETUP_N - 1);
  localparam logic [NIB_W-1:0] ADDR_BASE  = NIB_W'(SQI_CMD_NIBBLES);
  localparam fe_state_t        AFTER_ADDR = (DUMMY_NIBBLES == 0) ? DATA : DUMMY;

  fe_state_t        state_q, state_d;
  logic [NIB_W-1:0] nib_q, nib_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_fe_gck) begin
    if (i_fe_rst) begin
      state_q <= IDLE;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
    end
  end

  // NOTE: defaults are assigned first so no branch can leave a latch behind.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    if (i_seq_restart) begin
      state_d = IDLE;
      nib_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          nib_d = '0;
          if (i_seq_ctr == 2'd3) state_d = CMD;
        end
        CMD: begin
          nib_d = nib_q + 1'b1;
          if (nib_q == CMD_LAST) state_d = ADDR;
        end
        ADDR: begin
          nib_d = nib_q + 1'b1;
          if (nib_q == ADDR_LAST) state_d = AFTER_ADDR;
        end
        DUMMY: begin
          nib_d = nib_q + 1'b1;
          if (nib_q == SETUP_LAST) state_d = DATA;
        end
        DATA:    state_d = DATA;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_seq_cs_n = 1'b0;
    o_seq_oe   = 1'b0;
    o_seq_out  = '0;
    case (state_q)
      IDLE: o_seq_cs_n = 1'b1;
      CMD: begin
        o_seq_oe  = 1'b1;
        o_seq_out = nib_q[0] ? SQI_CMD[3:0] : SQI_CMD[7:4];
      end
      ADDR: begin
        o_seq_oe  = 1'b1;
        o_seq_out = addr_nibble(i_seq_pc, 3'(nib_q - ADDR_BASE));
      end
      default: ;
    endcase
  end

  assign o_seq_state = state_q;

endmodule

// File: rtl/idli_fetch_m.sv
// Nibble-serial fetch stage: sync counter, PC, redirect capture and 16-bit word assembly.
// Optional IDLI_FETCH_STATS_EN adds saturating redirect and immediate-word counters.
module idli_fetch_m
  import idli_pkg::*;
#(
  parameter logic [7:0] SQI_CMD       = SQI_CMD_DEFAULT,
  parameter int         DUMMY_NIBBLES = DUMMY_NIBBLES_DEFAULT
) (
  input  logic        i_fe_gck,
  input  logic        i_fe_rst,
  output ctr_t        o_fe_ctr,
  output logic        o_fe_sqi_cs_n,
  output logic        o_fe_sqi_oe,
  output logic [3:0]  o_fe_sqi_out,
  input  logic [3:0]  i_fe_sqi_in,
  input  logic        i_fe_redir,
  input  slice_t      i_fe_redir_slice,
  input  logic        i_fe_imm_next,
  output data_t       o_fe_enc,
  output logic        o_fe_enc_vld,
  output pc_t         o_fe_pc
`ifdef IDLI_FETCH_STATS_EN
  ,
  output logic [15:0] o_fe_restarts,
  output logic [15:0] o_fe_imm_cnt
`endif
);

  ctr_t      ctr_q;
  pc_t       pc_q, pc_d;
  pc_t       tgt_q, tgt_d;
  data_t     enc_q, enc_d;
  fe_state_t state;
  logic      last, word_done, redir_take;

  assign last       = (ctr_q == 2'd3);
  assign word_done  = (state == DATA) && last;
  assign redir_take = i_fe_redir && last;

  idli_fetch_sqi_seq_m #(
    .SQI_CMD       (SQI_CMD),
    .DUMMY_NIBBLES (DUMMY_NIBBLES)
  ) u_seq (
    .i_fe_gck      (i_fe_gck),
    .i_fe_rst      (i_fe_rst),
    .i_seq_ctr     (ctr_q),
    .i_seq_restart (redir_take),
    .i_seq_pc      (pc_q),
    .o_seq_state   (state),
    .o_seq_cs_n    (o_fe_sqi_cs_n),
    .o_seq_oe      (o_fe_sqi_oe),
    .o_seq_out     (o_fe_sqi_out)
  );

  always_comb begin
    tgt_d = tgt_q;
    if (i_fe_redir) tgt_d[{ctr_q, 2'b00} +: 4] = i_fe_redir_slice;

    // tgt_d already holds slice 3, so the accepted target loads in the same edge.
    pc_d = pc_q;
    if (redir_take)     pc_d = tgt_d;
    else if (word_done) pc_d = pc_q + 16'd1;

    enc_d = enc_q;
    if (state == DATA) enc_d[{ctr_q, 2'b00} +: 4] = i_fe_sqi_in;
  end

  always_ff @(posedge i_fe_gck) begin
    if (i_fe_rst) begin
      ctr_q <= '0;
      pc_q  <= '0;
      tgt_q <= '0;
      enc_q <= '0;
    end else begin
      ctr_q <= ctr_q + 2'd1;
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
      enc_q <= enc_d;
    end
  end

  // Top slice bypasses the flop so the whole word is usable at ctr==3.
  assign o_fe_enc     = word_done ? {i_fe_sqi_in, enc_q[11:0]} : enc_q;
  assign o_fe_enc_vld = word_done && !i_fe_imm_next && !i_fe_redir;
  assign o_fe_ctr     = ctr_q;
  assign o_fe_pc      = pc_q;

`ifdef IDLI_FETCH_STATS_EN
  logic [15:0] restarts_q, imm_cnt_q;

  always_ff @(posedge i_fe_gck) begin
    if (i_fe_rst) begin
      restarts_q <= '0;
      imm_cnt_q  <= '0;
    end else begin
      if (redir_take && (restarts_q != 16'hFFFF)) restarts_q <= restarts_q + 16'd1;
      if (word_done && i_fe_imm_next && !i_fe_redir && (imm_cnt_q != 16'hFFFF))
        imm_cnt_q <= imm_cnt_q + 16'd1;
    end
  end

  assign o_fe_restarts = restarts_q;
  assign o_fe_imm_cnt  = imm_cnt_q;
`endif

endmodule
